// File: rtl/afc_freq_cntr_if.sv
// Handshake bundle between the AFC engine (master) and the frequency counter (slave).
// dbg_state mirrors the counter FSM encoding (0=IDLE, 1=COUNT, 2=DONE) for observation.
interface afc_freq_cntr_if;
    logic        afc_cntr_rstn;
    logic        afc_cntr_en;
    logic        afc_cntr_datasyn;
    logic        vco_div_tick;
    logic [13:0] a2d_afc_ncntr;
    logic        ncntr_valid;
    logic        ncntr_ovf;
    logic        cntr_seq_err;
    logic [1:0]  dbg_state;

    modport master (
        output afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, vco_div_tick,
        input  a2d_afc_ncntr, ncntr_valid, ncntr_ovf, cntr_seq_err, dbg_state
    );

    modport slave (
        input  afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, vco_div_tick,
        output a2d_afc_ncntr, ncntr_valid, ncntr_ovf, cntr_seq_err, dbg_state
    );
endinterface

// File: rtl/afc_freq_cntr.sv
// Divided-VCO edge counter with a gated count window and a latched result for the AFC engine.
// Define AFC_FREQ_CNTR_SAT_EN to saturate the count at 14'h3FFF instead of wrapping to 0.
module afc_freq_cntr (
    input  logic             clk,
    input  logic             rst,
    afc_freq_cntr_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [13:0] r_cnt;
    logic [13:0] r_ncntr;
    logic        r_valid;
    logic        r_ovf;
    logic        r_err;

    logic        w_accept;
    logic        w_at_max;
    logic [13:0] w_cnt_next;

    // A tick is accepted whenever the window is open, whatever the state.
    assign w_accept = bus.afc_cntr_en & bus.vco_div_tick;
    assign w_at_max = (r_cnt == 14'h3FFF);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_accept) begin
            if (w_at_max) begin
`ifdef AFC_FREQ_CNTR_SAT_EN
                w_cnt_next = 14'h3FFF;
`else
                w_cnt_next = 14'h0000;
`endif
            end else begin
                w_cnt_next = r_cnt + 14'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ncntr <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (!bus.afc_cntr_rstn) begin
            // Engine clear keeps the last published result.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_next;
            if (w_accept && w_at_max) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.afc_cntr_en) begin
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.afc_cntr_datasyn) begin
                        r_err <= 1'b1;
                    end
                    if (!bus.afc_cntr_en) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Latch request outranks a reopened window.
                    if (bus.afc_cntr_datasyn) begin
                        r_ncntr <= r_cnt;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else if (bus.afc_cntr_en) begin
                        r_state <= COUNT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a2d_afc_ncntr = r_ncntr;
    assign bus.ncntr_valid   = r_valid;
    assign bus.ncntr_ovf     = r_ovf;
    assign bus.cntr_seq_err  = r_err;
    assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_afc_freq_cntr.sv
// Directed bench for afc_freq_cntr: windows, re-entry, protocol error, reset, overflow.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_afc_freq_cntr;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

`ifdef AFC_FREQ_CNTR_SAT_EN
    localparam int OVF_RESULT = 16383;
`else
    localparam int OVF_RESULT = 6;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    afc_freq_cntr_if bus ();

    afc_freq_cntr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: apply inputs at a falling edge, return at the next falling edge.
    task automatic cyc(input logic rstn, input logic en, input logic tick, input logic ds);
        bus.afc_cntr_rstn    = rstn;
        bus.afc_cntr_en      = en;
        bus.vco_div_tick     = tick;
        bus.afc_cntr_datasyn = ds;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_pulse();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.afc_cntr_rstn    = 1'b1;
        bus.afc_cntr_en      = 1'b0;
        bus.vco_div_tick     = 1'b0;
        bus.afc_cntr_datasyn = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_result", int'(bus.a2d_afc_ncntr), 0);
        check("rst_valid",  int'(bus.ncntr_valid), 0);
        check("rst_ovf",    int'(bus.ncntr_ovf), 0);
        check("rst_err",    int'(bus.cntr_seq_err), 0);
        check("rst_state",  int'(bus.dbg_state), int'(S_IDLE));
        rst = 1'b0;

        // 40-cycle window, tick every second cycle
        clear_pulse();
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'(i % 2), 1'b0);
        check("w20_count_state", int'(bus.dbg_state), int'(S_COUNT));
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("w20_done_state", int'(bus.dbg_state), int'(S_DONE));
        check("w20_not_latched", int'(bus.a2d_afc_ncntr), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("w20_result", int'(bus.a2d_afc_ncntr), 20);
        check("w20_valid", int'(bus.ncntr_valid), 1);
        check("w20_idle", int'(bus.dbg_state), int'(S_IDLE));
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("w20_valid_drop", int'(bus.ncntr_valid), 0);
        // datasyn while idle is ignored silently
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("idle_ds_err", int'(bus.cntr_seq_err), 0);
        check("idle_ds_valid", int'(bus.ncntr_valid), 0);
        check("idle_ds_result", int'(bus.a2d_afc_ncntr), 20);

        // split window: 10 + 5 without clearing
        clear_pulse();
        ticks(10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("split_result", int'(bus.a2d_afc_ncntr), 15);
        // re-entry from IDLE keeps the retained count
        ticks(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("reentry_result", int'(bus.a2d_afc_ncntr), 17);

        // datasyn mid-COUNT: flag, no latch, counting continues
        clear_pulse();
        ticks(4);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("seq_err_set", int'(bus.cntr_seq_err), 1);
        check("seq_no_latch", int'(bus.a2d_afc_ncntr), 17);
        check("seq_no_valid", int'(bus.ncntr_valid), 0);
        ticks(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("seq_result", int'(bus.a2d_afc_ncntr), 8);
        check("seq_err_sticky", int'(bus.cntr_seq_err), 1);
        clear_pulse();
        check("seq_err_clear", int'(bus.cntr_seq_err), 0);
        check("clear_holds_result", int'(bus.a2d_afc_ncntr), 8);

        // DONE with en and datasyn together: latch wins
        ticks(6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("both_result", int'(bus.a2d_afc_ncntr), 6);
        check("both_valid", int'(bus.ncntr_valid), 1);
        check("both_state", int'(bus.dbg_state), int'(S_IDLE));

        // async reset mid-COUNT
        clear_pulse();
        ticks(7);
        rst = 1'b1;
        #1;
        check("arst_result", int'(bus.a2d_afc_ncntr), 0);
        check("arst_state", int'(bus.dbg_state), int'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("arst_stay_idle", int'(bus.dbg_state), int'(S_IDLE));
        ticks(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("arst_new_result", int'(bus.a2d_afc_ncntr), 3);

        // overflow: 16390 ticks in one window
        clear_pulse();
        check("ovf_cleared", int'(bus.ncntr_ovf), 0);
        for (int i = 0; i < 16390; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            if (i == 16382) check("ovf_not_yet", int'(bus.ncntr_ovf), 0);
            if (i == 16383) check("ovf_set", int'(bus.ncntr_ovf), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_sticky", int'(bus.ncntr_ovf), 1);
        check("ovf_result", int'(bus.a2d_afc_ncntr), OVF_RESULT);
        clear_pulse();
        check("ovf_clear", int'(bus.ncntr_ovf), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
